// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between an add requester and nibble_serial_adder_ctrl.
//   start/a/b/c_in : requester -> adder (operands sampled when start is accepted)
//   busy/done      : adder status (busy during the shift phase, done one-cycle pulse)
//   sum/c_out      : result, held until the next accepted start
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit carry-lookahead slice,
// consuming one nibble per clock, LSB first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_ctrl_if
//           (start/a/b/c_in in; busy/done/sum/c_out out, all registered)
// WIDTH must be a multiple of 4 and at least 8; the interface instance must
// use the same WIDTH.
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cy_q, c_out_q, busy_q, done_q;

  logic             accept_c, last_c;
  logic [3:0]       p, g, c, s;
  logic             pp, gg, cy_n;

  // 4-bit CLA slice on the low nibble; only PP/GG leave the slice as carry.
  always_comb begin
    p    = a_q[3:0] ^ b_q[3:0];
    g    = a_q[3:0] & b_q[3:0];
    c[0] = cy_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c;
    pp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    cy_n = gg | (pp & cy_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next state; start is only honoured outside RUN, so DONE can restart directly.
  always_comb begin
    state_n  = state_q;
    accept_c = 1'b0;
    last_c   = (cnt_q == CNT_W'(NIBBLES - 1));
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n  = RUN;
          accept_c = 1'b1;
        end
      end
      RUN: begin
        if (last_c) state_n = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_n  = RUN;
          accept_c = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand/result shifters, carry, counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        cy_q  <= bus.c_in;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        // New nibble enters at the top so the LSB nibble ends up at bit 0.
        sum_q <= {s, sum_q[WIDTH-1:4]};
        a_q   <= a_q >> 4;
        b_q   <= b_q >> 4;
        cy_q  <= cy_n;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_c) c_out_q <= cy_n;
      end
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16): directed cases
// plus random operands compared with a plain-arithmetic reference.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; reports edges waited and cycles busy was seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) bcnt++;
      step();
      cyc++;
    end
  endtask

  // One complete add from IDLE/DONE with full latency and hold checks.
  task automatic do_add(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic ci);
    logic [WIDTH:0]   exp_full;
    logic [WIDTH-1:0] exp_sum;
    int cyc, bcnt;
    exp_full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    exp_sum   = exp_full[WIDTH-1:0];
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    step();
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.c_in  = 1'($urandom);
    wait_done(cyc, bcnt);
    check({tag, ".latency"}, cyc, NIBBLES);
    check({tag, ".busy_cycles"}, bcnt, NIBBLES);
    check({tag, ".done"}, bus.done, 1);
    check({tag, ".busy_in_done"}, bus.busy, 0);
    check({tag, ".sum"}, bus.sum, exp_sum);
    check({tag, ".c_out"}, bus.c_out, exp_full[WIDTH]);
    step();
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".sum_hold"}, bus.sum, exp_sum);
    check({tag, ".c_out_hold"}, bus.c_out, exp_full[WIDTH]);
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.sum", bus.sum, 0);
    check("reset.c_out", bus.c_out, 0);
    rst_n = 1'b1;
    step();
    check("idle.busy", bus.busy, 0);

    do_add("t1", 16'h1234, 16'h0001, 1'b0);
    do_add("t2", 16'hFFFF, 16'h0001, 1'b0);
    do_add("t3", 16'hFFFF, 16'hFFFF, 1'b1);
    do_add("zero", 16'h0000, 16'h0000, 1'b0);
    do_add("cin_only", 16'h0000, 16'h0000, 1'b1);

    // Start pulsed during RUN must be ignored.
    bus.start = 1'b1; bus.a = 16'hBBBB; bus.b = 16'h1111; bus.c_in = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001;
    step();
    bus.start = 1'b0;
    wait_done(cyc, bcnt);
    check("t4.done", bus.done, 1);
    check("t4.sum", bus.sum, 16'hCCCC);
    check("t4.c_out", bus.c_out, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done === 1'b1) dcnt++;
    end
    check("t4.extra_done", dcnt, 0);
    check("t4.idle_busy", bus.busy, 0);

    // Back-to-back: start held into DONE launches the next add immediately.
    bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.c_in = 1'b0;
    step();
    bus.start = 1'b0;
    wait_done(cyc, bcnt);
    check("t5.first_done", bus.done, 1);
    check("t5.first_sum", bus.sum, 16'h1010);
    bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'h8000; bus.c_in = 1'b0;
    step();
    bus.start = 1'b0;
    check("t5.no_idle_busy", bus.busy, 1);
    check("t5.no_idle_done", bus.done, 0);
    wait_done(cyc, bcnt);
    check("t5.latency", cyc, NIBBLES);
    check("t5.done", bus.done, 1);
    check("t5.sum", bus.sum, 16'h0000);
    check("t5.c_out", bus.c_out, 1);
    step();

    // Reset mid-RUN after a known non-zero result.
    do_add("t6.pre", 16'h1234, 16'h0001, 1'b0);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.c_in = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("t6.async_busy", bus.busy, 0);
    check("t6.async_done", bus.done, 0);
    check("t6.async_sum", bus.sum, 0);
    check("t6.async_c_out", bus.c_out, 0);
    step();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
    end
    check("t6.no_done_after_reset", dcnt, 0);
    do_add("t6.post", 16'hA5A5, 16'h5A5A, 1'b1);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      do_add($sformatf("rand%0d", i), ra, rb, rc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
